// File: rtl/receptor_serial.sv
// -----------------------------------------------------------------------------
// receptor_serial
//
// Serial-to-parallel frame receiver for the s_out stream of a 4-bit shift
// register running in serial-shift mode. A frame is: start bit (0), WIDTH data
// bits, an optional even-parity bit, and a stop bit (1). The data bits are
// reassembled MSB-first or LSB-first, depending on the bit order latched at the
// start bit.
//
// Parameters
//   WIDTH   data bits per frame (>= 2)
//   PARITY  1 = an even-parity bit follows the data, 0 = no parity bit
//
// Ports
//   clk      in   rising-edge clock
//   reset_L  in   asynchronous reset, active low
//   enb      in   sample enable (bit-period tick); when 0 all state holds
//   s_in     in   serial line, idle high
//   dir      in   bit order: 0 = MSB first, 1 = LSB first
//   q        out  last correctly received word
//   valid    out  one-cycle strobe: q was just updated
//   par_err  out  one-cycle strobe: parity mismatch
//   frm_err  out  one-cycle strobe: stop bit sampled 0
//   busy     out  high while a frame is in progress
// -----------------------------------------------------------------------------
module receptor_serial #(
  parameter int WIDTH  = 4,
  parameter bit PARITY = 1'b1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             s_in,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             par_err,
  output logic             frm_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;
  logic             pe_q, pe_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             par_err_q, par_err_d;
  logic             frm_err_q, frm_err_d;
  logic             busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    dir_d     = dir_q;
    pe_d      = pe_q;
    q_d       = q_q;
    // Strobes default low on every edge, so they last exactly one clock
    // even when enb is low on the following edge.
    valid_d   = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;

    if (enb) begin
      unique case (state_q)
        IDLE: begin
          // Compare against a clean 0: an unknown line level in simulation
          // evaluates false and does not start a frame.
          if (s_in == 1'b0) begin
            state_d = DATA;
            cnt_d   = '0;
            shreg_d = '0;
            dir_d   = dir;
            pe_d    = 1'b0;
          end
        end

        DATA: begin
          if (dir_q) shreg_d = {s_in, shreg_q[WIDTH-1:1]};
          else       shreg_d = {shreg_q[WIDTH-2:0], s_in};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = PARITY ? PAR : STOP;
        end

        PAR: begin
          // Odd total count of ones (data + parity bit) is an error.
          pe_d    = (^shreg_q) ^ s_in;
          state_d = STOP;
        end

        STOP: begin
          // A 0 here is a framing fault, never a new start bit.
          state_d = IDLE;
          if (!s_in)     frm_err_d = 1'b1;
          else if (pe_q) par_err_d = 1'b1;
          else begin
            q_d     = shreg_q;
            valid_d = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      dir_q     <= 1'b0;
      pe_q      <= 1'b0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      dir_q     <= dir_d;
      pe_q      <= pe_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      busy_q    <= busy_d;
    end
  end

  assign q       = q_q;
  assign valid   = valid_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_receptor_serial.sv
// -----------------------------------------------------------------------------
// tb_receptor_serial
//
// Self-checking bench for receptor_serial with default parameters (WIDTH=4,
// PARITY=1, 7-sample frames). A table of whole frames covers both bit orders,
// mid-frame dir changes, parity and framing errors and enb gating; hand-written
// sequences cover back-to-back frames, asynchronous reset mid-frame and a
// shift-register loopback.
// -----------------------------------------------------------------------------
module tb_receptor_serial;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enb;
  logic       s_in;
  logic       dir;
  logic [3:0] q;
  logic       valid;
  logic       par_err;
  logic       frm_err;
  logic       busy;

  receptor_serial #(.WIDTH(4), .PARITY(1'b1)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .enb     (enb),
    .s_in    (s_in),
    .dir     (dir),
    .q       (q),
    .valid   (valid),
    .par_err (par_err),
    .frm_err (frm_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Strobe monitor: counts high samples, so a strobe longer than one cycle
  // shows up as an extra pulse.
  int         n_valid  = 0;
  int         n_perr   = 0;
  int         n_ferr   = 0;
  int         en_edges = 0;
  int         valid_edge[$];
  logic [3:0] q_seen[$];

  always @(posedge clk) if (enb && reset_L) en_edges++;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      q_seen.push_back(q);
      valid_edge.push_back(en_edges);
    end
    if (par_err) n_perr++;
    if (frm_err) n_ferr++;
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One enabled sample followed by 'gap' disabled cycles.
  task automatic sample(input logic b, input int gap);
    s_in = b;
    enb  = 1'b1;
    @(posedge clk);
    #1;
    enb = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // bits[6] is the first sample on the line (start bit). dir is d0 at the
  // start and switches to d1 after the second data bit.
  task automatic send_frame(input logic [6:0] bits, input logic d0,
                            input logic d1, input int gap);
    dir = d0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) dir = d1;
      sample(bits[6-i], gap);
    end
  endtask

  typedef struct {
    logic [6:0] bits;
    logic       d0;
    logic       d1;
    int         gap;
    logic [3:0] exp_q;
    int         ev;
    int         ep;
    int         ef;
  } vec_t;

  vec_t vecs[8];

  int bv, bp, bf, bq;

  initial begin
    // start, data, parity, stop
    vecs[0] = '{7'b0_1011_1_1, 1'b0, 1'b1, 0, 4'b1011, 1, 0, 0}; // MSB first, dir flips
    vecs[1] = '{7'b0_1011_1_1, 1'b1, 1'b0, 0, 4'b1101, 1, 0, 0}; // LSB first, dir flips
    vecs[2] = '{7'b0_1011_0_1, 1'b0, 1'b0, 0, 4'b1101, 0, 1, 0}; // parity error
    vecs[3] = '{7'b0_1011_1_0, 1'b0, 1'b0, 0, 4'b1101, 0, 0, 1}; // framing error
    vecs[4] = '{7'b0_0110_0_1, 1'b0, 1'b0, 0, 4'b0110, 1, 0, 0}; // fresh frame after it
    vecs[5] = '{7'b0_1011_1_1, 1'b0, 1'b0, 3, 4'b1011, 1, 0, 0}; // gated MSB first
    vecs[6] = '{7'b0_1011_0_1, 1'b0, 1'b0, 3, 4'b1011, 0, 1, 0}; // gated parity error
    vecs[7] = '{7'b0_1011_1_1, 1'b1, 1'b0, 3, 4'b1101, 1, 0, 0}; // gated LSB first

    reset_L = 1'b0;
    enb     = 1'b0;
    s_in    = 1'b1;
    dir     = 1'b0;
    #12 reset_L = 1'b1;
    @(posedge clk);
    #1;
    check("reset_q",       q,       4'b0000);
    check("reset_valid",   valid,   1'b0);
    check("reset_par_err", par_err, 1'b0);
    check("reset_frm_err", frm_err, 1'b0);
    check("reset_busy",    busy,    1'b0);

    // Table-driven frames; one idle sample after each frame lets the strobe
    // of the stop edge land.
    for (int v = 0; v < 8; v++) begin
      bv = n_valid;
      bp = n_perr;
      bf = n_ferr;
      sample(1'b1, 0);
      send_frame(vecs[v].bits, vecs[v].d0, vecs[v].d1, vecs[v].gap);
      sample(1'b1, 0);
      check($sformatf("vec%0d_q", v),       q,            vecs[v].exp_q);
      check($sformatf("vec%0d_valid", v),   n_valid - bv, vecs[v].ev);
      check($sformatf("vec%0d_par_err", v), n_perr - bp,  vecs[v].ep);
      check($sformatf("vec%0d_frm_err", v), n_ferr - bf,  vecs[v].ef);
      check($sformatf("vec%0d_busy", v),    busy,         1'b0);
    end

    // Back-to-back frames 0000 and 1111, no idle slot between them.
    bv = n_valid;
    bq = q_seen.size();
    sample(1'b1, 0);
    send_frame(7'b0_0000_0_1, 1'b0, 1'b0, 0);
    send_frame(7'b0_1111_0_1, 1'b0, 1'b0, 0);
    sample(1'b1, 0);
    check("b2b_valid_count", n_valid - bv, 2);
    if (q_seen.size() == bq + 2) begin
      check("b2b_q_first",  q_seen[bq],   4'b0000);
      check("b2b_q_second", q_seen[bq+1], 4'b1111);
      check("b2b_spacing",  valid_edge[bq+1] - valid_edge[bq], 7);
    end else begin
      check("b2b_q_entries", q_seen.size() - bq, 2);
    end
    check("b2b_q_final", q, 4'b1111);

    // Asynchronous reset after two data bits.
    sample(1'b1, 0);
    sample(1'b0, 0);
    check("midreset_busy_before", busy, 1'b1);
    sample(1'b0, 0);
    sample(1'b1, 0);
    #2 reset_L = 1'b0;
    #1;
    check("midreset_q",       q,       4'b0000);
    check("midreset_valid",   valid,   1'b0);
    check("midreset_par_err", par_err, 1'b0);
    check("midreset_frm_err", frm_err, 1'b0);
    check("midreset_busy",    busy,    1'b0);
    #2 reset_L = 1'b1;
    @(posedge clk);
    #1;
    bv = n_valid;
    send_frame(7'b0_0110_0_1, 1'b0, 1'b0, 0);
    sample(1'b1, 0);
    check("after_reset_q",     q,            4'b0110);
    check("after_reset_valid", n_valid - bv, 1);

    // Loopback: a 4-bit left-shifting register supplies the data bits
    // (its MSB is s_out); the bench adds start, parity and stop.
    begin
      logic [3:0] words[4];
      logic [3:0] sr;
      words[0] = 4'h9;
      words[1] = 4'h3;
      words[2] = 4'hE;
      words[3] = 4'h5;
      bq = q_seen.size();
      dir = 1'b0;
      for (int w = 0; w < 4; w++) begin
        sr = words[w];
        sample(1'b0, 0);
        for (int b = 0; b < 4; b++) begin
          sample(sr[3], 0);
          sr = {sr[2:0], 1'b0};
        end
        sample(^words[w], 0);
        sample(1'b1, 0);
      end
      sample(1'b1, 0);
      check("loop_count", q_seen.size() - bq, 4);
      for (int w = 0; w < 4; w++) begin
        if (bq + w < q_seen.size())
          check($sformatf("loop_q%0d", w), q_seen[bq+w], words[w]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/receptor_serial.md
# receptor_serial

Serial-to-parallel receiver that consumes the `s_out` bit stream of the 4-bit shift register (`registro4bits`) when that register runs in serial-shift mode. It detects framed words (start bit, data bits, optional even parity, stop bit) and reassembles the data in either bit order. Each accepted word is presented on a parallel output with a one-cycle valid strobe. Parity and framing faults are flagged on separate one-cycle error strobes.

## Interface
- `WIDTH`, 4: data bits per frame (≥2).
- `PARITY`, 1: 1 means an even-parity bit follows the data; 0 means no parity bit.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset_L`  input  1  asynchronous reset, active-low.
- `enb`  input  1  sample enable; when 0 the block holds all state (bit-period tick).
- `s_in`  input  1  serial line, idle high (driven by the shift register `s_out`).
- `dir`  input  1  bit order: 0 = MSB first (left shift), 1 = LSB first (right shift).
- `q`  output  WIDTH  last correctly received word.
- `valid`  output  1  one-cycle strobe: `q` was just updated.
- `par_err`  output  1  one-cycle strobe: parity mismatch.
- `frm_err`  output  1  one-cycle strobe: stop bit sampled 0.
- `busy`  output  1  high while not in IDLE.

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, DATA, PAR, STOP. Transitions occur only on edges where `enb`=1.
- IDLE
  - `s_in`=0 is a start bit. Go to DATA, clear the bit counter and shift buffer, and latch `dir` into `dir_q`.
  - `s_in`=1 stays in IDLE.
- DATA
  - Each sample is shifted into the buffer.
  - `dir_q`=0: `buf <= {buf[WIDTH-2:0], s_in}`.
  - `dir_q`=1: `buf <= {s_in, buf[WIDTH-1:1]}`.
  - The counter increments per sample. The WIDTH-th sample goes to PAR if `PARITY`=1, otherwise to STOP.
- PAR
  - Sample the parity bit.
  - `pe <= (^buf) ^ s_in`; 1 means the total number of ones is odd, which is an error.
  - Go to STOP.
- STOP: sample the stop bit and go to IDLE.
  - `s_in`=1 and no parity error: `q <= buf`, pulse `valid`.
  - `s_in`=1 and parity error: pulse `par_err`; `q` is unchanged.
  - `s_in`=0: pulse `frm_err` only, even if parity also failed; `q` is unchanged.
  - A 0 in the stop slot is not reinterpreted as a start bit.
- `dir` changes mid-frame are ignored; the value latched at the start bit governs the whole frame.
- `enb`=0 cycles are invisible to the protocol. The state, counter, buffer and `q` hold, and the strobes are 0.
- `s_in`=x/z in IDLE is not a start bit. Only a clean 0 starts a frame.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - State IDLE, `q`=0, `valid`=0, `par_err`=0, `frm_err`=0, `busy`=0.
  - Counter, buffer, `dir_q` and `pe` are cleared.
  - A partially received frame is discarded.
  - The first start bit can be sampled on the first enabled edge after `reset_L` rises.
- All outputs are registered.
  - `valid`/`par_err`/`frm_err` go high for exactly one `clk` cycle after the stop-sampling edge, regardless of `enb` on the following edge.
  - `q` changes on the same edge that raises `valid`.
- Frame length is 1+WIDTH+PARITY+1 enabled samples, which is 7 for the defaults.
- `busy` rises on the edge after the start bit is sampled. It falls on the edge after the stop bit is sampled.
- Back-to-back: a start bit may be sampled on the very next enabled edge after the stop bit, with no mandatory idle slot.
- Counter width is `$clog2(WIDTH+1)`. It never wraps within a frame and is reset on every start bit.

## Test plan
- Reset mid-frame:
  - Stimulus: assert `reset_L`=0 during DATA (after 2 data bits).
  - Required response: all outputs are 0 immediately, without waiting for a clock edge. After release, the frame 0,0,1,1,0,0,1 with `dir`=0 gives `q`=0110 and `valid` once.
- MSB-first:
  - Stimulus: `dir`=0, `enb`=1, serial 1,0,1,0,1,1,1,1 (idle, start, 1011, parity 1, stop).
  - Required response: `q`=1011, one `valid` pulse, no errors.
- LSB-first, `dir` toggled mid-frame:
  - Stimulus: `dir`=1 at the start bit, the same bits as the MSB-first case, then `dir` changed to 0 after bit 2.
  - Required response: `q`=1101, `valid` pulse.
- Errors:
  - Parity: frame 0,1,0,1,1,0,1 gives a `par_err` pulse with `q` unchanged.
  - Framing: frame 0,1,0,1,1,1,0 gives a `frm_err` pulse only; the block returns to IDLE and the next 0 starts a fresh frame.
- `enb` gating and back-to-back:
  - Stimulus: `enb` low for 3 cycles between every pair of samples. Then two frames sent consecutively, 0000 (parity 0) and 1111 (parity 0).
  - Required response: the gated frame decodes to the same `q` and the same strobe count as the ungated one. The consecutive frames give `q`=0000 then `q`=1111, with two `valid` pulses 7 enabled samples apart.
- Shift-register loopback:
  - Stimulus: `registro4bits` in serial-shift mode (`modo`=00, `dir`=0) driving `s_in`, framed by the bench.
  - Required response: `q` matches the words shifted out, in order.
